// File: rtl/lsu.sv
// lsu: load/store unit bridging the ex stage to a single-beat memory bus
module lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [4:0]  req_rd_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        hold_flag_o,
  output logic        err_misaligned_o,
  output logic        err_timeout_o
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t      state;
  logic        we_q, uns_q;
  logic [1:0]  size_q, off_q;
  logic [4:0]  rd_q;
  logic [31:0] cnt;
  logic        mis;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] ld;
  // alignment check, lane selection and load extension
  always_comb begin
    mis = req_size_i == 2'b11 || (req_size_i == 2'b01 && req_addr_i[0]) ||
          (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
    lane8 = bus_rdata_i[{off_q, 3'b000} +: 8];
    lane16 = bus_rdata_i[{off_q[1], 4'b0000} +: 16];
    ld = size_q == 2'b00 ? {{24{~uns_q & lane8[7]}}, lane8} :
         size_q == 2'b01 ? {{16{~uns_q & lane16[15]}}, lane16} : bus_rdata_i;
    hold_flag_o = !rst && (state != IDLE || (req_valid_i && !mis));
  end
  // transaction FSM with registered bus, writeback and error outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      {we_q, uns_q, size_q, off_q, rd_q} <= '0;
      {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} <= '0;
      {reg_we_o, reg_waddr_o, reg_wdata_o} <= '0;
      {err_misaligned_o, err_timeout_o} <= '0;
    end else begin
      err_misaligned_o <= 1'b0;
      err_timeout_o <= 1'b0;
      reg_we_o <= 1'b0;
      case (state)
        IDLE: if (req_valid_i) begin
          if (mis) begin
            err_misaligned_o <= 1'b1;
          end else begin
            {we_q, uns_q, size_q, off_q, rd_q} <= {req_we_i, req_unsigned_i, req_size_i, req_addr_i[1:0], req_rd_i};
            cnt <= '0;
            state <= BUS;
            bus_req_o <= 1'b1;
            bus_we_o <= req_we_i;
            bus_addr_o <= {req_addr_i[31:2], 2'b00};
            bus_be_o <= req_size_i == 2'b10 ? 4'b1111 : (req_size_i == 2'b01 ? 4'b0011 : 4'b0001) << req_addr_i[1:0];
            bus_wdata_o <= req_size_i == 2'b10 ? req_wdata_i :
                           req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : {4{req_wdata_i[7:0]}};
          end
        end
        BUS: begin
          cnt <= cnt + 32'd1;
          if (bus_ack_i) begin
            {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} <= '0;
            if (!we_q) begin
              reg_wdata_o <= ld;
              reg_we_o <= rd_q != 5'd0;
              reg_waddr_o <= rd_q;
              state <= RESP;
            end else begin
              state <= IDLE;
            end
          end else if (TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1)) begin
            {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} <= '0;
            err_timeout_o <= 1'b1;
            state <= IDLE;
          end
        end
        RESP: begin
          reg_wdata_o <= '0;
          reg_waddr_o <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
